// File: rtl/handshake_arbiter.sv
// Four-requester round-robin front end for a four-phase handshake sender; grant, data1, src_id and newdata1 register one cycle after the IDLE decision.
// No backpressure on requesters beyond holding req until grant; busy1 gates launch, a missing busy1 times out into sticky err.
module handshake_arbiter #(
  parameter int N       = 8,
  parameter int TIMEOUT = 15
) (
  input  logic           clk1,
  input  logic           reset,
  input  logic [3:0]     req,
  input  logic [4*N-1:0] req_data,
  output logic [3:0]     grant,
  output logic [N-1:0]   data1,
  output logic           newdata1,
  input  logic           busy1,
  output logic [1:0]     src_id,
  output logic           done,
  output logic           err
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  localparam logic [3:0] TO_LAST = 4'(TIMEOUT - 1);

  state_t             state;
  logic [1:0]         ptr;
  logic [3:0]         cnt;
  logic [1:0]         sel;
  logic               found;
  logic [3:0][N-1:0]  words;

  assign words = req_data;

  // Search starts just past the last winner so it ends up with lowest priority.
  always_comb begin
    logic [1:0] idx;
    sel   = ptr;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= 4; k++) begin
      idx = ptr + 2'(k);
      if (!found && req[idx]) begin
        sel   = idx;
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk1) begin
    if (reset) begin
      state    <= IDLE;
      grant    <= '0;
      newdata1 <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      data1    <= '0;
      src_id   <= '0;
      ptr      <= 2'd3;
      cnt      <= '0;
    end else begin
      grant    <= '0;
      newdata1 <= 1'b0;
      done     <= 1'b0;
      case (state)
        IDLE: begin
          // A handshake still busy from an earlier transfer must drain before launching.
          if (found && !busy1) begin
            grant    <= 4'b0001 << sel;
            data1    <= words[sel];
            src_id   <= sel;
            ptr      <= sel;
            newdata1 <= 1'b1;
            state    <= LAUNCH;
          end
        end
        LAUNCH: begin
          cnt   <= '0;
          state <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (busy1) begin
            state <= WAIT_DONE;
          end else if (cnt >= TO_LAST) begin
            err   <= 1'b1;
            state <= IDLE;
          end else if (cnt != 4'hF) begin
            cnt <= cnt + 4'd1;
          end
        end
        WAIT_DONE: begin
          if (!busy1) begin
            done  <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  a_grant_onehot: assert property (@(posedge clk1) disable iff (reset) $onehot0(grant));
  a_launch_with_grant: assert property (@(posedge clk1) disable iff (reset) newdata1 |-> (grant != 4'b0));
  a_done_not_launch: assert property (@(posedge clk1) disable iff (reset) done |-> !newdata1);

endmodule

// File: doc/handshake_arbiter.md
HANDSHAKE_ARBITER -- requirements
Module: handshake_arbiter

Interface
REQ-001 Parameter N, default 8: data width, matching the four-phase handshake data1 width.
REQ-002 Parameter TIMEOUT, default 15: maximum clk1 cycles to wait for busy1 after newdata1.
REQ-003 clk1  input  1  sole clock, sender domain of the four-phase handshake; all logic on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req  input  4  requester i has a word pending; held high until its grant pulse.
REQ-006 req_data  input  4*N  requester i data in bits [i*N+N-1 : i*N].
REQ-007 grant  output  4  one-hot, one-cycle pulse; requester i's word captured.
REQ-008 data1  output  N  registered word driven into the handshake.
REQ-009 newdata1  output  1  one-cycle launch pulse into the handshake.
REQ-010 busy1  input  1  handshake busy flag, already in the clk1 domain.
REQ-011 src_id  output  2  index of the requester whose word is in flight.
REQ-012 done  output  1  one-cycle pulse when a transfer completes.
REQ-013 err  output  1  sticky timeout flag.

Function
REQ-014 The FSM SHALL have exactly four states: IDLE, LAUNCH, WAIT_BUSY and WAIT_DONE.
REQ-015 IDLE SHALL grant only when req != 0 and busy1 == 0, and SHALL stay in IDLE otherwise.
REQ-016 On a grant the block SHALL, in one cycle, pulse grant[sel], load data1 <= req_data[sel], load src_id <= sel, update ptr <= sel, and move to LAUNCH.
REQ-017 Arbitration SHALL be round-robin: search order starts at ptr+1 mod 4 and wraps to ptr; the last winner has lowest priority.
REQ-018 In LAUNCH, newdata1 SHALL be 1 for exactly that one cycle, and the state SHALL then move to WAIT_BUSY.
REQ-019 WAIT_BUSY SHALL move to WAIT_DONE on the first cycle busy1 == 1; a busy1 already high in the cycle after LAUNCH SHALL count.
REQ-020 WAIT_BUSY SHALL count cycles with a 4-bit saturating counter; after TIMEOUT cycles without busy1, it SHALL set err = 1, return to IDLE, and issue no done pulse.
REQ-021 WAIT_DONE SHALL wait for busy1 == 0, then pulse done for one cycle and return to IDLE; this wait has no timeout.
REQ-022 data1 and src_id SHALL hold stable from the grant cycle until the next grant.
REQ-023 Minimum grant spacing SHALL be 4 cycles: grant, launch, at least one WAIT_BUSY cycle, then the done/IDLE cycle.
REQ-024 Requests arriving while not in IDLE SHALL be ignored until IDLE; no request is lost while its req stays high.
REQ-025 If several req bits rise simultaneously, exactly one grant SHALL be issued per transfer.
REQ-026 A req dropped before its grant SHALL be forfeited; no error is flagged.
REQ-027 err SHALL stay set until reset and SHALL NOT block further arbitration.

Reset
REQ-028 While reset == 1 at a rising edge: state = IDLE; grant = 0, newdata1 = 0, done = 0, err = 0; data1 = 0; src_id = 0; ptr = 3 (so requester 0 has first priority); timeout counter = 0.
REQ-029 A reset in any state SHALL abort the transfer with no done pulse.
REQ-030 After reset, the block SHALL not grant until busy1 == 0, so a handshake still busy from before the reset is drained first.

Verification
REQ-031 Single request: req = 4'b0100, req_data[23:16] = 8'hA5, busy1 high 3 cycles after LAUNCH for 6 cycles -> grant = 4'b0100 once, data1 = 8'hA5, src_id = 2, one newdata1 pulse, done one cycle after busy1 falls, err = 0.
REQ-032 Contention: req = 4'b1111 held, each transfer completing normally -> grant order 0, 1, 2, 3, 0; each data1 matches the granting slice.
REQ-033 Fairness: req[0] always high, req[2] raised mid-transfer of requester 0 -> the next grant goes to 2, then back to 0.
REQ-034 Timeout: busy1 stuck at 0 after a grant -> after 15 WAIT_BUSY cycles err = 1, no done pulse, the next pending request is granted normally, and err stays at 1.
REQ-035 Reset mid-transfer: reset asserted in WAIT_DONE with busy1 = 1 -> all outputs take their reset values, no grant while busy1 = 1, first grant goes to requester 0 after busy1 falls.
REQ-036 Back-to-back: req = 4'b0001 held, busy1 high the cycle after each newdata1 for 1 cycle -> grants exactly 4 cycles apart.
